// File: rtl/slot_sram_pkg.sv
// Shared types and width helpers for the time-slot SRAM sequencer.
package slot_sram_pkg;

  typedef enum logic [1:0] {
    OP_IDLE,
    OP_ENG_RD,
    OP_CPU_RD,
    OP_CPU_WR
  } ram_op_t;

  localparam int unsigned DEF_VOICES = 16;
  localparam int unsigned DEF_SLOTS  = 4;
  localparam int unsigned SLOT_W     = $clog2(DEF_SLOTS);
  localparam int unsigned VOICE_W    = $clog2(DEF_VOICES);

  // Index width for a counter of n states; never narrower than one bit.
  function automatic int unsigned idx_w(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/slot_counter.sv
// Slot/voice counter chain with a registered frame-sync for the last slot of the last voice.
module slot_counter
  import slot_sram_pkg::*;
#(
  parameter int unsigned SLOTS  = DEF_SLOTS,
  parameter int unsigned VOICES = DEF_VOICES
) (
  input  logic                     clk,
  input  logic                     rst_n,
  output logic [idx_w(SLOTS)-1:0]  slot,
  output logic [idx_w(VOICES)-1:0] voice,
  output logic                     fsync
);

  localparam int unsigned SW = idx_w(SLOTS);
  localparam int unsigned VW = idx_w(VOICES);
  localparam logic [SW-1:0] SLOT_MAX  = SW'(SLOTS - 1);
  localparam logic [VW-1:0] VOICE_MAX = VW'(VOICES - 1);

  logic [SW-1:0] slot_nxt;
  logic [VW-1:0] voice_nxt;

  // Slot wraps every voice; voice advances on slot wrap and wraps per frame.
  always_comb begin
    slot_nxt  = slot + SW'(1);
    voice_nxt = voice;
    if (slot == SLOT_MAX) begin
      slot_nxt  = '0;
      voice_nxt = (voice == VOICE_MAX) ? '0 : voice + VW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot  <= '0;
      voice <= '0;
      fsync <= 1'b0;
    end else begin
      slot  <= slot_nxt;
      voice <= voice_nxt;
      fsync <= (slot_nxt == SLOT_MAX) && (voice_nxt == VOICE_MAX);
    end
  end

endmodule

// File: rtl/slot_sram_sequencer.sv
// Time-slot SRAM sequencer: engine reads in every slot except the reserved CPU slot,
// which serves a one-deep CPU request buffer.
module slot_sram_sequencer
  import slot_sram_pkg::*;
#(
  parameter int unsigned VOICES          = DEF_VOICES,
  parameter int unsigned SLOTS_PER_VOICE = DEF_SLOTS,
  parameter int unsigned CPU_SLOT        = 3,
  parameter int unsigned ADDR_W          = 11,
  parameter int unsigned DATA_W          = 8
) (
  input  logic                               SYNC_IN,
  input  logic                               RESET_N_IN,
  output logic [idx_w(SLOTS_PER_VOICE)-1:0]  SLOT_OUT,
  output logic [idx_w(VOICES)-1:0]           VOICE_OUT,
  output logic                               FSYNC_OUT,
  input  logic [ADDR_W-1:0]                  ENG_ADDR_IN,
  output logic [DATA_W-1:0]                  ENG_DATA_OUT,
  output logic                               ENG_VALID_OUT,
  input  logic                               CPU_REQ_IN,
  input  logic                               CPU_RW_IN,
  input  logic [ADDR_W-1:0]                  CPU_ADDR_IN,
  input  logic [DATA_W-1:0]                  CPU_WDATA_IN,
  output logic [DATA_W-1:0]                  CPU_RDATA_OUT,
  output logic                               CPU_ACK_OUT,
  output logic                               CPU_BUSY_OUT,
  output logic                               CPU_ERR_OUT,
  output logic [ADDR_W-1:0]                  RAM_A_OUT,
  output logic [DATA_W-1:0]                  RAM_D_OUT,
  input  logic [DATA_W-1:0]                  RAM_D_IN,
  output logic                               RAM_D_DRIVE_OUT,
  output logic                               RAM_OE_N_OUT,
  output logic                               RAM_WE_N_OUT
);

  localparam int unsigned SW = idx_w(SLOTS_PER_VOICE);
  localparam logic [SW-1:0] CPU_SLOT_IDX = SW'(CPU_SLOT);

  typedef struct packed {
    logic              rw;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } cpu_req_t;

  ram_op_t  op_nxt;
  ram_op_t  op_q;
  cpu_req_t req_q;
  logic     busy_q;
  logic     accept;
  logic     drop;
  logic     cpu_done;

  slot_counter #(
    .SLOTS  (SLOTS_PER_VOICE),
    .VOICES (VOICES)
  ) u_slot_counter (
    .clk   (SYNC_IN),
    .rst_n (RESET_N_IN),
    .slot  (SLOT_OUT),
    .voice (VOICE_OUT),
    .fsync (FSYNC_OUT)
  );

  // Issue decision from the slot currently shown; the CPU slot only runs a buffered request.
  always_comb begin
    op_nxt = OP_IDLE;
    if (SLOT_OUT != CPU_SLOT_IDX) begin
      op_nxt = OP_ENG_RD;
    end else if (busy_q) begin
      op_nxt = req_q.rw ? OP_CPU_RD : OP_CPU_WR;
    end
  end

  assign accept   = CPU_REQ_IN && !busy_q;
  assign drop     = CPU_REQ_IN && busy_q;
  assign cpu_done = (op_q == OP_CPU_RD) || (op_q == OP_CPU_WR);
  assign CPU_BUSY_OUT = busy_q;

  // One-deep request buffer; busy clears at the edge that raises the ack.
  always_ff @(posedge SYNC_IN or negedge RESET_N_IN) begin
    if (!RESET_N_IN) begin
      req_q       <= '0;
      busy_q      <= 1'b0;
      CPU_ERR_OUT <= 1'b0;
    end else begin
      CPU_ERR_OUT <= drop;
      if (accept) begin
        req_q  <= '{rw: CPU_RW_IN, addr: CPU_ADDR_IN, wdata: CPU_WDATA_IN};
        busy_q <= 1'b1;
      end else if (cpu_done) begin
        busy_q <= 1'b0;
      end
    end
  end

  // SRAM pin stage; the address is held through idle slots.
  always_ff @(posedge SYNC_IN or negedge RESET_N_IN) begin
    if (!RESET_N_IN) begin
      op_q            <= OP_IDLE;
      RAM_A_OUT       <= '0;
      RAM_D_OUT       <= '0;
      RAM_D_DRIVE_OUT <= 1'b0;
      RAM_OE_N_OUT    <= 1'b1;
      RAM_WE_N_OUT    <= 1'b1;
    end else begin
      op_q            <= op_nxt;
      RAM_D_DRIVE_OUT <= 1'b0;
      RAM_OE_N_OUT    <= 1'b1;
      RAM_WE_N_OUT    <= 1'b1;
      case (op_nxt)
        OP_ENG_RD: begin
          RAM_A_OUT    <= ENG_ADDR_IN;
          RAM_OE_N_OUT <= 1'b0;
        end
        OP_CPU_RD: begin
          RAM_A_OUT    <= req_q.addr;
          RAM_OE_N_OUT <= 1'b0;
        end
        OP_CPU_WR: begin
          RAM_A_OUT       <= req_q.addr;
          RAM_D_OUT       <= req_q.wdata;
          RAM_D_DRIVE_OUT <= 1'b1;
          RAM_WE_N_OUT    <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  // Return path: read data captured at the end of the access cycle.
  always_ff @(posedge SYNC_IN or negedge RESET_N_IN) begin
    if (!RESET_N_IN) begin
      ENG_DATA_OUT  <= '0;
      ENG_VALID_OUT <= 1'b0;
      CPU_RDATA_OUT <= '0;
      CPU_ACK_OUT   <= 1'b0;
    end else begin
      ENG_VALID_OUT <= (op_q == OP_ENG_RD);
      CPU_ACK_OUT   <= cpu_done;
      if (op_q == OP_ENG_RD) begin
        ENG_DATA_OUT <= RAM_D_IN;
      end
      if (op_q == OP_CPU_RD) begin
        CPU_RDATA_OUT <= RAM_D_IN;
      end
    end
  end

endmodule
